sw_array_scheduler: RTL

Job controller for the linear Smith-Waterman processing-element array. It accepts one alignment job at a time: a query of up to N_PE bases and a target length. It loads the query into the PEs and streams the target bases into PE0 as one gap-free enable burst. It then waits for the last PE's valid flag and returns the unbiased high score through a ready/valid result port. It also owns the shared match/mismatch/gap penalty registers that feed every PE.

---
 rtl/sw_array_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sw_array_scheduler.sv
// rtl/sw_array_scheduler.sv - Smith-Waterman PE array job controller and penalty registers
// Optional DRAIN watchdog enabled by defining SW_SCHED_WATCHDOG_EN.
module sw_array_scheduler #(
  parameter int SCORE_WIDTH = 12,
  parameter int N_PE        = 16,
  parameter int LEN_W       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [2*N_PE-1:0]      job_query,
  input  logic [LEN_W-1:0]       job_tlen,
  input  logic                   tgt_valid,
  output logic                   tgt_ready,
  input  logic [1:0]             tgt_base,
  output logic                   pe_en,
  output logic [1:0]             pe_data,
  output logic [2*N_PE-1:0]      pe_query,
  input  logic                   arr_vld,
  input  logic [SCORE_WIDTH-1:0] arr_high,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-2:0] res_score,
  output logic                   res_err,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [SCORE_WIDTH-1:0] cfg_wdata,
  output logic                   cfg_err,
  output logic [SCORE_WIDTH-1:0] match,
  output logic [SCORE_WIDTH-1:0] mismatch,
  output logic [SCORE_WIDTH-1:0] gap_open,
  output logic [SCORE_WIDTH-1:0] gap_extend,
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, RESULT} state_t;

  localparam logic [SCORE_WIDTH-1:0] MATCH_RST = SCORE_WIDTH'(2);
  localparam logic [SCORE_WIDTH-1:0] MIS_RST   = {SCORE_WIDTH{1'b1}};
  localparam logic [SCORE_WIDTH-1:0] GOPEN_RST = {{(SCORE_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [SCORE_WIDTH-1:0] GEXT_RST  = {SCORE_WIDTH{1'b1}};

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     job_ready_q, job_ready_d;
  logic                     tgt_ready_q, tgt_ready_d;
  logic                     pe_en_q, pe_en_d;
  logic [1:0]               pe_data_q, pe_data_d;
  logic [2*N_PE-1:0]        pe_query_q, pe_query_d;
  logic                     res_valid_q, res_valid_d;
  logic [SCORE_WIDTH-2:0]   res_score_q, res_score_d;
  logic                     res_err_q, res_err_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     busy_q, busy_d;
  logic [SCORE_WIDTH-1:0]   match_q, match_d, mismatch_q, mismatch_d;
  logic [SCORE_WIDTH-1:0]   gap_open_q, gap_open_d, gap_extend_q, gap_extend_d;
`ifdef SW_SCHED_WATCHDOG_EN
  localparam int WD_LIMIT = 2*N_PE + 7;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0]          wd_q, wd_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    tgt_ready_d  = 1'b0;
    pe_en_d      = 1'b0;
    pe_data_d    = 2'b00;
    pe_query_d   = pe_query_q;
    res_valid_d  = res_valid_q;
    res_score_d  = res_score_q;
    res_err_d    = res_err_q;
    cfg_err_d    = 1'b0;
    match_d      = match_q;
    mismatch_d   = mismatch_q;
    gap_open_d   = gap_open_q;
    gap_extend_d = gap_extend_q;
`ifdef SW_SCHED_WATCHDOG_EN
    wd_d         = '0;
`endif
    case (state_q)
      IDLE: begin
        if (job_valid && job_ready_q) begin
          pe_query_d = job_query;
          cnt_d      = job_tlen;
          err_d      = 1'b0;
          if (job_tlen == '0) begin
            state_d     = RESULT;
            res_valid_d = 1'b1;
            res_score_d = '0;
            res_err_d   = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d     = STREAM;
        tgt_ready_d = 1'b1;
      end
      STREAM: begin
        // Underflow still occupies a slot so the PE enable burst stays unbroken.
        pe_en_d   = 1'b1;
        pe_data_d = tgt_valid ? tgt_base : 2'b00;
        if (!tgt_valid) err_d = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        else                    tgt_ready_d = 1'b1;
      end
      DRAIN: begin
`ifdef SW_SCHED_WATCHDOG_EN
        wd_d = wd_q + 1'b1;
`endif
        if (arr_vld) begin
          state_d     = RESULT;
          res_valid_d = 1'b1;
          res_score_d = arr_high[SCORE_WIDTH-1] ? arr_high[SCORE_WIDTH-2:0] : '0;
          res_err_d   = err_q;
        end
`ifdef SW_SCHED_WATCHDOG_EN
        else if (wd_q == WD_W'(WD_LIMIT)) begin
          state_d     = RESULT;
          res_valid_d = 1'b1;
          res_score_d = '0;
          res_err_d   = 1'b1;
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_we) begin
      if (state_q == IDLE) begin
        case (cfg_addr)
          2'd0:    match_d      = cfg_wdata;
          2'd1:    mismatch_d   = cfg_wdata;
          2'd2:    gap_open_d   = cfg_wdata;
          default: gap_extend_d = cfg_wdata;
        endcase
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    job_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      job_ready_q  <= 1'b1;
      tgt_ready_q  <= 1'b0;
      pe_en_q      <= 1'b0;
      pe_data_q    <= 2'b00;
      pe_query_q   <= '0;
      res_valid_q  <= 1'b0;
      res_score_q  <= '0;
      res_err_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      match_q      <= MATCH_RST;
      mismatch_q   <= MIS_RST;
      gap_open_q   <= GOPEN_RST;
      gap_extend_q <= GEXT_RST;
`ifdef SW_SCHED_WATCHDOG_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      job_ready_q  <= job_ready_d;
      tgt_ready_q  <= tgt_ready_d;
      pe_en_q      <= pe_en_d;
      pe_data_q    <= pe_data_d;
      pe_query_q   <= pe_query_d;
      res_valid_q  <= res_valid_d;
      res_score_q  <= res_score_d;
      res_err_q    <= res_err_d;
      cfg_err_q    <= cfg_err_d;
      busy_q       <= busy_d;
      match_q      <= match_d;
      mismatch_q   <= mismatch_d;
      gap_open_q   <= gap_open_d;
      gap_extend_q <= gap_extend_d;
`ifdef SW_SCHED_WATCHDOG_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign job_ready  = job_ready_q;
  assign tgt_ready  = tgt_ready_q;
  assign pe_en      = pe_en_q;
  assign pe_data    = pe_data_q;
  assign pe_query   = pe_query_q;
  assign res_valid  = res_valid_q;
  assign res_score  = res_score_q;
  assign res_err    = res_err_q;
  assign cfg_err    = cfg_err_q;
  assign busy       = busy_q;
  assign match      = match_q;
  assign mismatch   = mismatch_q;
  assign gap_open   = gap_open_q;
  assign gap_extend = gap_extend_q;

endmodule
